conv_sequencer: RTL

- Controller and MAC datapath that sequences a 2D valid-mode convolution over the X and W matrices held by the input memory block.
- Waits for inputs_loaded, then for each output position:
  - generates X and W read addresses;
  - accumulates B plus the K*K signed products;
  - presents the result on a valid/ready output stream.
- Pulses compute_finished after the last result is accepted, which releases the input memories for the next load.

---
 rtl/conv_sequencer.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/conv_sequencer.sv
// Sequencer and MAC datapath for a 2D valid-mode convolution over X (R x C) and W (K x K).
// Addresses one term per cycle, accumulates B plus K*K products, streams each result out.
module conv_sequencer #(
    parameter int INW  = 10,
    parameter int R    = 15,
    parameter int C    = 13,
    parameter int MAXK = 7,
    parameter int OUTW = 2*INW + $clog2(MAXK*MAXK)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          inputs_loaded,
    input  logic [$clog2(MAXK+1)-1:0]     K,
    input  logic [INW-1:0]                B,
    output logic [$clog2(R*C)-1:0]        X_read_addr,
    input  logic [INW-1:0]                X_data,
    output logic [$clog2(MAXK*MAXK)-1:0]  W_read_addr,
    input  logic [INW-1:0]                W_data,
    output logic                          compute_finished,
    output logic [OUTW-1:0]               OUT_TDATA,
    output logic                          OUT_TVALID,
    input  logic                          OUT_TREADY
);
    localparam int KW  = $clog2(MAXK+1);
    localparam int XAW = $clog2(R*C);
    localparam int WAW = $clog2(MAXK*MAXK);

    typedef enum logic [2:0] {IDLE, RUN, DRAIN, OUT, FINISH} state_t;

    state_t state, state_nxt;

    logic [KW-1:0]     k_q, km1, i, j;
    logic [INW-1:0]    b_q;
    logic [XAW-1:0]    r, c, row_base, k_ext, r_last, c_last;
    logic [XAW-1:0]    r_nxt, c_nxt, row_base_nxt;
    logic              issued_d, first_d;
    logic [OUTW-1:0]   acc, prod_ext, b_ext;
    logic [2*INW-1:0]  x_ext, w_ext, prod;
    logic              last_term, last_out, k_bad, col_wrap;

    assign km1       = k_q - KW'(1);
    assign k_ext     = XAW'(k_q);
    assign r_last    = XAW'(R) - k_ext;
    assign c_last    = XAW'(C) - k_ext;
    assign last_term = (i == km1) && (j == km1);
    assign last_out  = (r == r_last) && (c == c_last);
    assign k_bad     = (K < KW'(2)) || (32'(K) > R) || (32'(K) > C);

    // Signed multiply done on sign-extended operands so plain modular arithmetic stays exact.
    assign x_ext    = {{INW{X_data[INW-1]}}, X_data};
    assign w_ext    = {{INW{W_data[INW-1]}}, W_data};
    assign prod     = x_ext * w_ext;
    assign prod_ext = {{(OUTW-2*INW){prod[2*INW-1]}}, prod};
    assign b_ext    = {{(OUTW-INW){b_q[INW-1]}}, b_q};

    assign col_wrap     = (c == c_last);
    assign c_nxt        = col_wrap ? '0 : c + XAW'(1);
    assign r_nxt        = col_wrap ? r + XAW'(1) : r;
    assign row_base_nxt = col_wrap ? row_base + XAW'(C) : row_base;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt        = state;
        OUT_TVALID       = 1'b0;
        OUT_TDATA        = '0;
        compute_finished = 1'b0;
        case (state)
            IDLE: begin
                if (inputs_loaded) state_nxt = k_bad ? FINISH : RUN;
            end
            RUN: begin
                if (!inputs_loaded)  state_nxt = IDLE;
                else if (last_term)  state_nxt = DRAIN;
            end
            DRAIN: begin
                state_nxt = inputs_loaded ? OUT : IDLE;
            end
            OUT: begin
                OUT_TVALID = 1'b1;
                OUT_TDATA  = acc;
                if (!inputs_loaded)  state_nxt = IDLE;
                else if (OUT_TREADY) state_nxt = last_out ? FINISH : RUN;
            end
            FINISH: begin
                compute_finished = 1'b1;
                state_nxt        = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Read data lags the address by one cycle, so accumulation follows a one-cycle issue flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            k_q         <= '0;
            b_q         <= '0;
            r           <= '0;
            c           <= '0;
            row_base    <= '0;
            i           <= '0;
            j           <= '0;
            issued_d    <= 1'b0;
            first_d     <= 1'b0;
            acc         <= '0;
            X_read_addr <= '0;
            W_read_addr <= '0;
        end else begin
            issued_d <= (state == RUN);
            first_d  <= (state == RUN) && (i == '0) && (j == '0);
            if (issued_d) acc <= first_d ? (b_ext + prod_ext) : (acc + prod_ext);
            case (state)
                IDLE: begin
                    if (inputs_loaded) begin
                        k_q <= K;
                        b_q <= B;
                    end
                    if (state_nxt == RUN) begin
                        r           <= '0;
                        c           <= '0;
                        row_base    <= '0;
                        i           <= '0;
                        j           <= '0;
                        X_read_addr <= '0;
                        W_read_addr <= '0;
                    end
                end
                RUN: begin
                    if (!last_term) begin
                        W_read_addr <= W_read_addr + WAW'(1);
                        if (j == km1) begin
                            i           <= i + KW'(1);
                            j           <= '0;
                            X_read_addr <= X_read_addr + XAW'(C) - k_ext + XAW'(1);
                        end else begin
                            j           <= j + KW'(1);
                            X_read_addr <= X_read_addr + XAW'(1);
                        end
                    end
                end
                OUT: begin
                    if (state_nxt == RUN) begin
                        r           <= r_nxt;
                        c           <= c_nxt;
                        row_base    <= row_base_nxt;
                        i           <= '0;
                        j           <= '0;
                        X_read_addr <= row_base_nxt + c_nxt;
                        W_read_addr <= '0;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
